// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM/IO port arbiter serving instruction block fills and LSB loads/stores
// Optional round-robin arbitration between fetch and LSB: define MEM_CTRL_RR_ARB_EN.
module mem_ctrl #(
  parameter int         BLK_BYTES  = 64,
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full,
  input  logic                   rollback,
  input  logic                   if_en,
  input  logic [31:0]            if_pc,
  output logic                   if_done,
  output logic [BLK_BYTES*8-1:0] if_data,
  input  logic                   lsb_en,
  input  logic                   lsb_wr,
  input  logic [31:0]            lsb_addr,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_wdata,
  output logic                   lsb_done,
  output logic [31:0]            lsb_rdata
);
  localparam int LOG = $clog2(BLK_BYTES);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t                 r_state;
  logic [LOG-1:0]         r_cnt;
  logic [LOG-1:0]         r_last;
  logic [31:0]            r_a;
  logic [7:0]             r_dout;
  logic                   r_wr;
  logic [31:0]            r_wdata;
  logic                   r_if_done;
  logic                   r_lsb_done;
  logic [BLK_BYTES*8-1:0] r_if_data;
  logic [31:0]            r_lsb_rdata;

  logic           w_io_store;
  logic           w_lsb_go;
  logic           w_if_go;
  logic           w_pick_lsb;
  logic [LOG-1:0] w_n_m1;
  logic [1:0]     w_nidx;
  logic           w_unused;

  assign w_unused   = ^if_pc[LOG-1:0];
  assign w_io_store = lsb_wr && (lsb_addr[17:16] == IO_ADDR_HI);
  // A source whose done pulse is still high is skipped so its held en is not taken twice.
  assign w_lsb_go   = lsb_en && !r_lsb_done && !(w_io_store && io_buffer_full) && !rollback;
  assign w_if_go    = if_en && !r_if_done && !rollback;
  assign w_nidx     = r_cnt[1:0] + 2'd1;

  always_comb begin
    w_n_m1 = LOG'(3);
    case (lsb_len)
      2'b00:   w_n_m1 = LOG'(0);
      2'b01:   w_n_m1 = LOG'(1);
      default: w_n_m1 = LOG'(3);
    endcase
  end

`ifdef MEM_CTRL_RR_ARB_EN
  logic r_last_grant;  // 1 = LSB was served last
  assign w_pick_lsb = w_lsb_go && (!w_if_go || !r_last_grant);
`else
  assign w_pick_lsb = w_lsb_go;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= '0;
      r_a         <= '0;
      r_dout      <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_if_done   <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_if_data   <= '0;
      r_lsb_rdata <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
      r_last_grant <= 1'b0;
`endif
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_lsb) begin
            r_cnt       <= '0;
            r_last      <= w_n_m1;
            r_a         <= lsb_addr;
            r_wdata     <= lsb_wdata;
            r_lsb_rdata <= '0;
            r_wr        <= lsb_wr;
            r_dout      <= lsb_wdata[7:0];
            r_state     <= lsb_wr ? LS_WR : LS_RD;
`ifdef MEM_CTRL_RR_ARB_EN
            r_last_grant <= 1'b1;
`endif
          end else if (w_if_go) begin
            r_cnt   <= '0;
            r_last  <= LOG'(BLK_BYTES - 1);
            r_a     <= {if_pc[31:LOG], {LOG{1'b0}}};
            r_wr    <= 1'b0;
            r_state <= IF_RD;
`ifdef MEM_CTRL_RR_ARB_EN
            r_last_grant <= 1'b0;
`endif
          end
        end
        IF_RD, LS_RD: begin
          if (rollback) begin
            r_state <= IDLE;
          end else begin
            // mem_din holds the byte addressed during the cycle that just ended.
            if (r_state == IF_RD)
              r_if_data[{r_cnt, 3'b000} +: 8] <= mem_din;
            else
              r_lsb_rdata[{r_cnt[1:0], 3'b000} +: 8] <= mem_din;
            r_a   <= r_a + 32'd1;
            r_cnt <= r_cnt + LOG'(1);
            if (r_cnt == r_last) begin
              r_state <= IDLE;
              if (r_state == IF_RD) r_if_done <= 1'b1;
              else                  r_lsb_done <= 1'b1;
            end
          end
        end
        LS_WR: begin
          // Stores are already committed, so rollback does not interrupt them.
          if (r_cnt == r_last) begin
            r_wr       <= 1'b0;
            r_lsb_done <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_a    <= r_a + 32'd1;
            r_dout <= r_wdata[{w_nidx, 3'b000} +: 8];
            r_cnt  <= r_cnt + LOG'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_a     = r_a;
  assign mem_dout  = r_dout;
  assign mem_wr    = r_wr;
  assign if_done   = r_if_done;
  assign if_data   = r_if_data;
  assign lsb_done  = r_lsb_done;
  assign lsb_rdata = r_lsb_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed scoreboard bench for mem_ctrl against a byte RAM model
// Expected arbitration order follows MEM_CTRL_RR_ARB_EN when it is defined.
module tb_mem_ctrl;
  logic         clk = 1'b0;
  logic         rst, rdy;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full, rollback;
  logic         if_en;
  logic [31:0]  if_pc;
  logic         if_done;
  logic [511:0] if_data;
  logic         lsb_en, lsb_wr;
  logic [31:0]  lsb_addr;
  logic [1:0]   lsb_len;
  logic [31:0]  lsb_wdata;
  logic         lsb_done;
  logic [31:0]  lsb_rdata;

  mem_ctrl #(.BLK_BYTES(64), .IO_ADDR_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .rollback(rollback),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write committed on the edge where mem_wr is seen.
  logic [7:0] ram [0:131071];
  int         wr_cycles = 0;
  int         io_cnt = 0;
  logic [7:0] io_last = 8'h00;
  assign mem_din = ram[mem_a[16:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 131072; i++) ram[i] <= i[7:0];
    end else if (rdy && mem_wr) begin
      ram[mem_a[16:0]] <= mem_dout;
      wr_cycles <= wr_cycles + 1;
      if (mem_a[17:16] == 2'b11) begin
        io_cnt  <= io_cnt + 1;
        io_last <= mem_dout;
      end
    end
  end

  int if_pulses = 0;
  int lsb_pulses = 0;
  always @(negedge clk) begin
    if (if_done)  if_pulses  <= if_pulses + 1;
    if (lsb_done) lsb_pulses <= lsb_pulses + 1;
  end

  typedef struct { logic is_load; logic [31:0] data; } lsb_exp_t;
  logic [511:0] if_q [$];
  lsb_exp_t     lsb_q [$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] blk(input logic [7:0] start);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = start + k[7:0];
    return r;
  endfunction

  task automatic pop_if();
    chk("if_sb_nonempty", 512'(if_q.size() > 0), 512'(1));
    if (if_q.size() > 0) chk("if_data", if_data, if_q.pop_front());
  endtask

  task automatic pop_lsb();
    lsb_exp_t e;
    chk("lsb_sb_nonempty", 512'(lsb_q.size() > 0), 512'(1));
    if (lsb_q.size() > 0) begin
      e = lsb_q.pop_front();
      if (e.is_load) chk("lsb_rdata", 512'(lsb_rdata), 512'(e.data));
    end
  endtask

  task automatic wait_done(input bit want_if, input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(want_if ? if_done : lsb_done) && cyc < bound);
  endtask

  task automatic lsb_txn(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input string tag,
                         input logic [31:0] rdata);
    int cyc;
    lsb_q.push_back('{!wr, rdata});
    lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_wdata = wdata; lsb_en = 1'b1;
    tick();
    chk({tag, "_addr"}, 512'(mem_a), 512'(addr));
    wait_done(1'b0, 100, cyc);
    chk({tag, "_lat"}, 512'(cyc), 512'(lat));
    if (lsb_done) pop_lsb();
    lsb_en = 1'b0;
    tick();
  endtask

  initial begin
    int cyc, w0, io0, if_at, ls_at, p0;
    logic [31:0] a0;
    logic seen_wr;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; rollback = 1'b0;
    if_en = 1'b0; if_pc = '0; lsb_en = 1'b0; lsb_wr = 1'b0;
    lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
    repeat (3) tick();
    chk("rst_mem_a", 512'(mem_a), 512'(0));
    chk("rst_mem_wr", 512'(mem_wr), 512'(0));
    chk("rst_mem_dout", 512'(mem_dout), 512'(0));
    chk("rst_dones", 512'({if_done, lsb_done}), 512'(0));
    chk("rst_data", if_data | 512'(lsb_rdata), 512'(0));
    rst = 1'b0;
    tick();

    // 1: block fill, latency, one-cycle done, no re-accept while done is high
    if_q.push_back(blk(8'h40));
    if_pc = 32'h1044; if_en = 1'b1;
    tick();
    chk("t1_base", 512'(mem_a), 512'(32'h1040));
    wait_done(1'b1, 200, cyc);
    chk("t1_lat", 512'(cyc), 512'(64));
    if (if_done) pop_if();
    tick();
    chk("t1_pulse_width", 512'(if_done), 512'(0));
    chk("t1_no_reaccept", 512'(mem_a == 32'h1040), 512'(0));
    if_en = 1'b0;
    tick();

    // 2: word store then halfword load
    w0 = wr_cycles;
    lsb_txn(1'b1, 2'b10, 32'h200, 32'hDEADBEEF, 4, "t2_st", 32'h0);
    chk("t2_wr_cycles", 512'(wr_cycles - w0), 512'(4));
    chk("t2_ram", 512'({ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}), 512'(32'hDEADBEEF));
    lsb_txn(1'b0, 2'b01, 32'h202, 32'h0, 2, "t2_ld", 32'h0000DEAD);

    // 3: simultaneous fetch and byte load
    if_q.push_back(blk(8'h00));
    lsb_q.push_back('{1'b1, 32'h05});
    if_pc = 32'h100; if_en = 1'b1;
    lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h205; lsb_en = 1'b1;
    tick();
`ifdef MEM_CTRL_RR_ARB_EN
    chk("t3_first", 512'(mem_a), 512'(32'h100));
`else
    chk("t3_first", 512'(mem_a), 512'(32'h205));
`endif
    cyc = 0; if_at = 0; ls_at = 0;
    while ((if_at == 0 || ls_at == 0) && cyc < 300) begin
      tick();
      cyc++;
      if (if_done)  begin if_at = cyc; pop_if();  if_en = 1'b0;  end
      if (lsb_done) begin ls_at = cyc; pop_lsb(); lsb_en = 1'b0; end
    end
`ifdef MEM_CTRL_RR_ARB_EN
    chk("t3_if_at", 512'(if_at), 512'(64));
    chk("t3_lsb_at", 512'(ls_at), 512'(66));
`else
    chk("t3_lsb_at", 512'(ls_at), 512'(1));
    chk("t3_if_at", 512'(if_at), 512'(66));
`endif
    tick();

    // 4: IO store held off while the IO buffer is full
    io0 = io_cnt; seen_wr = 1'b0;
    lsb_q.push_back('{1'b0, 32'h0});
    io_buffer_full = 1'b1;
    lsb_wr = 1'b1; lsb_len = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h41; lsb_en = 1'b1;
    repeat (5) begin
      tick();
      seen_wr = seen_wr | mem_wr | lsb_done;
    end
    chk("t4_stalled", 512'(seen_wr), 512'(0));
    io_buffer_full = 1'b0;
    tick();
    chk("t4_wr", 512'({mem_wr, mem_dout, mem_a}), 512'({1'b1, 8'h41, 32'h30000}));
    tick();
    chk("t4_done", 512'({lsb_done, mem_wr}), 512'({1'b1, 1'b0}));
    if (lsb_done) pop_lsb();
    lsb_en = 1'b0;
    tick();
    chk("t4_io_count", 512'(io_cnt - io0), 512'(1));
    chk("t4_io_byte", 512'(io_last), 512'(8'h41));

    // 5: rollback aborts a fetch but not a store
    p0 = if_pulses;
    if_pc = 32'h2000; if_en = 1'b1;
    tick();
    repeat (30) tick();
    rollback = 1'b1; if_en = 1'b0;
    tick();
    rollback = 1'b0;
    a0 = mem_a;
    repeat (40) tick();
    chk("t5_idle_addr", 512'(mem_a), 512'(a0));
    chk("t5_no_if_done", 512'(if_pulses - p0), 512'(0));
    chk("t5_no_wr", 512'(mem_wr), 512'(0));
    w0 = wr_cycles;
    lsb_q.push_back('{1'b0, 32'h0});
    lsb_wr = 1'b1; lsb_len = 2'b10; lsb_addr = 32'h300; lsb_wdata = 32'h11223344; lsb_en = 1'b1;
    tick();
    tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    wait_done(1'b0, 20, cyc);
    chk("t5_st_lat", 512'(cyc + 2), 512'(4));
    if (lsb_done) pop_lsb();
    lsb_en = 1'b0;
    tick();
    chk("t5_st_wr_cycles", 512'(wr_cycles - w0), 512'(4));
    chk("t5_st_ram", 512'({ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]}), 512'(32'h11223344));

    // 6: rdy low for three cycles in the middle of a word load
    lsb_q.push_back('{1'b1, 32'h43424140});
    lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h1040; lsb_en = 1'b1;
    tick();
    tick();
    a0 = mem_a;
    rdy = 1'b0;
    repeat (3) tick();
    chk("t6_frozen", 512'({mem_a, lsb_done}), 512'({a0, 1'b0}));
    rdy = 1'b1;
    wait_done(1'b0, 20, cyc);
    chk("t6_lat", 512'(cyc + 4), 512'(7));
    if (lsb_done) pop_lsb();
    lsb_en = 1'b0;
    tick();

    chk("if_pulses_total", 512'(if_pulses), 512'(2));
    chk("lsb_pulses_total", 512'(lsb_pulses), 512'(6));
    chk("sb_drained", 512'(if_q.size() + lsb_q.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
